// File: rtl/controlador_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, mux/ALU codes
// and the 4-bit state encoding exposed on the debug port.
package controlador_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_BUSCA      = 4'd1,
    S_DECODIFICA = 4'd2,
    S_ENDERECO   = 4'd3,
    S_MEM_LE     = 4'd4,
    S_WB_LW      = 4'd5,
    S_MEM_ESC    = 4'd6,
    S_EXEC_R     = 4'd7,
    S_WB_R       = 4'd8,
    S_BEQ        = 4'd9,
    S_JUMP       = 4'd10,
    S_WB_ADDI    = 4'd11,
    S_ILEGAL     = 4'd12
  } estado_t;

endpackage

// File: rtl/controlador_saidas.sv
// Moore output decoder: maps the current state to datapath strobes and selects.
// Only BUSCA looks at mem_ready, to hold IR/PC writes until the fetch completes.
module controlador_saidas
  import controlador_pkg::*;
(
  input  estado_t     estado_i,
  input  logic        mem_ready_i,
  output logic        pcwrite_o,
  output logic        pcwritecond_o,
  output logic        iord_o,
  output logic        memread_o,
  output logic        memwrite_o,
  output logic        memtoreg_o,
  output logic        irwrite_o,
  output logic        regwrite_o,
  output logic        regdst_o,
  output logic        alusrca_o,
  output logic [1:0]  alusrcb_o,
  output logic [1:0]  pcsource_o,
  output logic [1:0]  aluop_o,
  output logic        ilegal_o
);

  always_comb begin
    pcwrite_o     = 1'b0;
    pcwritecond_o = 1'b0;
    iord_o        = 1'b0;
    memread_o     = 1'b0;
    memwrite_o    = 1'b0;
    memtoreg_o    = 1'b0;
    irwrite_o     = 1'b0;
    regwrite_o    = 1'b0;
    regdst_o      = 1'b0;
    alusrca_o     = 1'b0;
    alusrcb_o     = SRCB_REG;
    pcsource_o    = PC_ALU;
    aluop_o       = ALUOP_ADD;
    ilegal_o      = 1'b0;
    case (estado_i)
      S_BUSCA: begin
        memread_o = 1'b1;
        alusrcb_o = SRCB_4;
        irwrite_o = mem_ready_i;
        pcwrite_o = mem_ready_i;
      end
      S_DECODIFICA: alusrcb_o = SRCB_IMM_SH;
      S_ENDERECO: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      S_MEM_LE: begin
        memread_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_WB_LW: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
      end
      S_MEM_ESC: begin
        memwrite_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_EXEC_R: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
      end
      S_WB_ADDI: regwrite_o = 1'b1;
      S_BEQ: begin
        alusrca_o     = 1'b1;
        aluop_o       = ALUOP_SUB;
        pcwritecond_o = 1'b1;
        pcsource_o    = PC_ALUOUT;
      end
      S_JUMP: begin
        pcwrite_o  = 1'b1;
        pcsource_o = PC_JUMP;
      end
      S_ILEGAL: ilegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/controlador_multiciclo.sv
// Multicycle MIPS main control: state register, opcode capture and next-state logic.
// Outputs are decoded purely from the state, so reset clears them asynchronously.
module controlador_multiciclo
  import controlador_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ALUOP_W      = 2,
  parameter bit PERMITE_ADDI = 1'b1,
  parameter bit PERMITE_J    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] entrada,
  input  logic                mem_ready,
  output logic                pcwrite,
  output logic                pcwritecond,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                irwrite,
  output logic                regwrite,
  output logic                regdst,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsource,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                ilegal,
  output logic [3:0]          estado
);

  estado_t             estado_q, estado_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [1:0]          aluop_int;

  function automatic logic eh_op(input logic [OPCODE_W-1:0] op, input logic [5:0] ref_op);
    return op == OPCODE_W'(ref_op);
  endfunction

  always_comb begin
    estado_d = estado_q;
    opcode_d = opcode_q;
    case (estado_q)
      S_RESET: estado_d = S_BUSCA;
      S_BUSCA: if (mem_ready) estado_d = S_DECODIFICA;
      S_DECODIFICA: begin
        opcode_d = entrada;
        if (eh_op(entrada, OP_R))
          estado_d = S_EXEC_R;
        else if (eh_op(entrada, OP_LW) || eh_op(entrada, OP_SW) ||
                 (PERMITE_ADDI && eh_op(entrada, OP_ADDI)))
          estado_d = S_ENDERECO;
        else if (eh_op(entrada, OP_BEQ))
          estado_d = S_BEQ;
        else if (PERMITE_J && eh_op(entrada, OP_J))
          estado_d = S_JUMP;
        else
          estado_d = S_ILEGAL;
      end
      // Only lw, sw and an enabled addi can reach ENDERECO, so addi is the fall-through.
      S_ENDERECO: begin
        if (eh_op(opcode_q, OP_LW))      estado_d = S_MEM_LE;
        else if (eh_op(opcode_q, OP_SW)) estado_d = S_MEM_ESC;
        else                             estado_d = S_WB_ADDI;
      end
      S_MEM_LE:  if (mem_ready) estado_d = S_WB_LW;
      S_MEM_ESC: if (mem_ready) estado_d = S_BUSCA;
      S_EXEC_R:  estado_d = S_WB_R;
      S_WB_LW, S_WB_R, S_WB_ADDI, S_BEQ, S_JUMP, S_ILEGAL: estado_d = S_BUSCA;
      default:   estado_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= S_RESET;
      opcode_q <= '0;
    end else begin
      estado_q <= estado_d;
      opcode_q <= opcode_d;
    end
  end

  controlador_saidas u_saidas (
    .estado_i      (estado_q),
    .mem_ready_i   (mem_ready),
    .pcwrite_o     (pcwrite),
    .pcwritecond_o (pcwritecond),
    .iord_o        (iord),
    .memread_o     (memread),
    .memwrite_o    (memwrite),
    .memtoreg_o    (memtoreg),
    .irwrite_o     (irwrite),
    .regwrite_o    (regwrite),
    .regdst_o      (regdst),
    .alusrca_o     (alusrca),
    .alusrcb_o     (alusrcb),
    .pcsource_o    (pcsource),
    .aluop_o       (aluop_int),
    .ilegal_o      (ilegal)
  );

  assign aluop  = ALUOP_W'(aluop_int);
  assign estado = estado_q;

endmodule

// File: tb/tb_controlador_multiciclo.sv
// Bench for controlador_multiciclo: random and directed instruction streams checked
// cycle by cycle against a per-instruction phase model; a second instance has addi disabled.
module tb_controlador_multiciclo;
  import controlador_pkg::*;

  typedef struct packed {
    logic pcw, pcwc, iord, memrd, memwr, m2r, irw, regw, regdst, asa;
    logic [1:0] asb, pcs, aop;
    logic ilg;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0] entrada_a, entrada_b;
  logic       mem_ready_a, mem_ready_b;
  logic pcwrite_a, pcwritecond_a, iord_a, memread_a, memwrite_a, memtoreg_a, irwrite_a;
  logic regwrite_a, regdst_a, alusrca_a, ilegal_a;
  logic pcwrite_b, pcwritecond_b, iord_b, memread_b, memwrite_b, memtoreg_b, irwrite_b;
  logic regwrite_b, regdst_b, alusrca_b, ilegal_b;
  logic [1:0] alusrcb_a, pcsource_a, aluop_a, alusrcb_b, pcsource_b, aluop_b;
  logic [3:0] estado_a, estado_b;
  outs_t obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;

  controlador_multiciclo dut_a (
    .clk(clk), .rst_n(rst_n), .entrada(entrada_a), .mem_ready(mem_ready_a),
    .pcwrite(pcwrite_a), .pcwritecond(pcwritecond_a), .iord(iord_a), .memread(memread_a),
    .memwrite(memwrite_a), .memtoreg(memtoreg_a), .irwrite(irwrite_a), .regwrite(regwrite_a),
    .regdst(regdst_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a), .pcsource(pcsource_a),
    .aluop(aluop_a), .ilegal(ilegal_a), .estado(estado_a)
  );

  controlador_multiciclo #(.PERMITE_ADDI(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .entrada(entrada_b), .mem_ready(mem_ready_b),
    .pcwrite(pcwrite_b), .pcwritecond(pcwritecond_b), .iord(iord_b), .memread(memread_b),
    .memwrite(memwrite_b), .memtoreg(memtoreg_b), .irwrite(irwrite_b), .regwrite(regwrite_b),
    .regdst(regdst_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b), .pcsource(pcsource_b),
    .aluop(aluop_b), .ilegal(ilegal_b), .estado(estado_b)
  );

  assign obs_a = {pcwrite_a, pcwritecond_a, iord_a, memread_a, memwrite_a, memtoreg_a,
                  irwrite_a, regwrite_a, regdst_a, alusrca_a, alusrcb_a, pcsource_a,
                  aluop_a, ilegal_a};
  assign obs_b = {pcwrite_b, pcwritecond_b, iord_b, memread_b, memwrite_b, memtoreg_b,
                  irwrite_b, regwrite_b, regdst_b, alusrca_b, alusrcb_b, pcsource_b,
                  aluop_b, ilegal_b};

  // Expected strobes for each named phase of an instruction.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic mr);
    outs_t o;
    o = '0;
    if (st == S_BUSCA)      begin o.memrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
    if (st == S_DECODIFICA) o.asb = 2'b11;
    if (st == S_ENDERECO)   begin o.asa = 1; o.asb = 2'b10; end
    if (st == S_MEM_LE)     begin o.memrd = 1; o.iord = 1; end
    if (st == S_WB_LW)      begin o.regw = 1; o.m2r = 1; end
    if (st == S_MEM_ESC)    begin o.memwr = 1; o.iord = 1; end
    if (st == S_EXEC_R)     begin o.asa = 1; o.aop = 2'b10; end
    if (st == S_WB_R)       begin o.regw = 1; o.regdst = 1; end
    if (st == S_WB_ADDI)    o.regw = 1;
    if (st == S_BEQ)        begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; end
    if (st == S_JUMP)       begin o.pcw = 1; o.pcs = 2'b10; end
    if (st == S_ILEGAL)     o.ilg = 1;
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input bit sel, input logic [3:0] st, input logic mr);
    logic [3:0] e;
    outs_t o, x;
    e = sel ? estado_b : estado_a;
    o = sel ? obs_b : obs_a;
    x = exp_outs(st, mr);
    vectors++;
    assert (e === st) else begin
      miscompares++;
      $error("FAIL estado_%s: observed %0d expected %0d", sel ? "b" : "a", e, st);
    end
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL saidas_%s (estado %0d): observed %h expected %h", sel ? "b" : "a", st, o, x);
    end
  endtask

  task automatic step(input bit sel, input logic [3:0] st, input logic mr, input logic [5:0] ent);
    if (sel) begin mem_ready_b = mr; entrada_b = ent; end
    else     begin mem_ready_a = mr; entrada_a = ent; end
    #1;
    chk(sel, st, mr);
    @(posedge clk);
    #1;
  endtask

  // One instruction from its fetch up to the cycle before the next fetch.
  task automatic run_instr(input bit sel, input logic [5:0] op, input int fs, input int ms,
                           input bit addi_ok, input bit j_ok);
    for (int i = 0; i < fs; i++) step(sel, S_BUSCA, 1'b0, rnd6());
    step(sel, S_BUSCA, 1'b1, rnd6());
    step(sel, S_DECODIFICA, rb(), op);
    if (op == 6'b000000) begin
      step(sel, S_EXEC_R, rb(), rnd6());
      step(sel, S_WB_R, rb(), rnd6());
    end else if (op == 6'b100011) begin
      step(sel, S_ENDERECO, rb(), rnd6());
      for (int i = 0; i < ms; i++) step(sel, S_MEM_LE, 1'b0, rnd6());
      step(sel, S_MEM_LE, 1'b1, rnd6());
      step(sel, S_WB_LW, rb(), rnd6());
    end else if (op == 6'b101011) begin
      step(sel, S_ENDERECO, rb(), rnd6());
      for (int i = 0; i < ms; i++) step(sel, S_MEM_ESC, 1'b0, rnd6());
      step(sel, S_MEM_ESC, 1'b1, rnd6());
    end else if (op == 6'b001000 && addi_ok) begin
      step(sel, S_ENDERECO, rb(), rnd6());
      step(sel, S_WB_ADDI, rb(), rnd6());
    end else if (op == 6'b000100) begin
      step(sel, S_BEQ, rb(), rnd6());
    end else if (op == 6'b000010 && j_ok) begin
      step(sel, S_JUMP, rb(), rnd6());
    end else begin
      step(sel, S_ILEGAL, rb(), rnd6());
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      4: op = 6'b001000;
      5: op = 6'b000010;
      default: op = rnd6();
    endcase
    return op;
  endfunction

  initial begin
    rst_n = 1'b0;
    entrada_a = '0; entrada_b = '0;
    mem_ready_a = 1'b0; mem_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(0, S_RESET, 1'b0);
    chk(1, S_RESET, 1'b0);
    #2 rst_n = 1'b1;
    step(0, S_RESET, 1'b1, rnd6());

    // Directed: R, lw with 2 memory stalls, sw, beq, j, addi, illegal opcode.
    run_instr(0, 6'b000000, 0, 0, 1, 1);
    run_instr(0, 6'b100011, 0, 2, 1, 1);
    run_instr(0, 6'b101011, 1, 1, 1, 1);
    run_instr(0, 6'b000100, 0, 0, 1, 1);
    run_instr(0, 6'b000010, 0, 0, 1, 1);
    run_instr(0, 6'b001000, 0, 0, 1, 1);
    run_instr(0, 6'b111111, 0, 0, 1, 1);

    for (int n = 0; n < 40; n++)
      run_instr(0, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), 1, 1);

    // Asynchronous reset while stalled in MEM_LE.
    step(0, S_BUSCA, 1'b1, rnd6());
    step(0, S_DECODIFICA, rb(), 6'b100011);
    step(0, S_ENDERECO, rb(), rnd6());
    mem_ready_a = 1'b0;
    #1 chk(0, S_MEM_LE, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk(0, S_RESET, 1'b0);
    chk(1, S_RESET, 1'b0);
    @(posedge clk);
    #1 chk(0, S_RESET, 1'b0);
    #2 rst_n = 1'b1;
    step(0, S_RESET, 1'b1, rnd6());
    run_instr(0, 6'b000000, 0, 0, 1, 1);
    run_instr(0, 6'b100011, 0, 0, 1, 1);

    // Instance with addi disabled has been idling in a stalled fetch.
    run_instr(1, 6'b001000, 1, 0, 0, 1);
    run_instr(1, 6'b000000, 0, 0, 0, 1);
    run_instr(1, 6'b000010, 0, 0, 0, 1);
    run_instr(1, 6'b101011, 0, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controlador_multiciclo.md
# controlador_multiciclo

Multicycle main control unit for the MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It replaces the single-cycle opcode decoder. It adds `addi`, `j`, illegal-opcode trapping and a memory-ready stall handshake. It sits between the instruction register's opcode field, the shared instruction/data memory, the ALU control and the register file.

## Interface
- `OPCODE_W`, 6: opcode field width.
- `ALUOP_W`, 2: width of the `aluop` bus to ALU control.
- `PERMITE_ADDI`, 1: 1 enables `addi` (001000); 0 makes it illegal.
- `PERMITE_J`, 1: 1 enables `j` (000010); 0 makes it illegal.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `entrada`  in  OPCODE_W  opcode from the instruction register; sampled only in DECODIFICA.
- `mem_ready`  in  1  memory has completed the current access.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca`  out  1 each  datapath strobes and mux selects.
- `alusrcb`  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended imm, 11 shifted imm.
- `pcsource`  out  2  PC select: 00 ALU, 01 ALUOut, 10 jump target.
- `aluop`  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded; upper bits 0.
- `ilegal`  out  1  pulses for one cycle on an unsupported opcode.
- `estado`  out  4  current state encoding, for debug.

## Operation
- States: RESET, BUSCA, DECODIFICA, ENDERECO, MEM_LE, WB_LW, MEM_ESC, EXEC_R, WB_R, BEQ, JUMP, WB_ADDI, ILEGAL.
- The only asserted outputs in each state are listed below; all others are 0.
- RESET: all outputs 0. Always goes to BUSCA on the next edge.
- BUSCA:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite=1 and pcwrite=1 only while mem_ready=1.
  - Stays in BUSCA while mem_ready=0; goes to DECODIFICA when mem_ready=1.
- DECODIFICA: alusrca=0, alusrcb=11, aluop=00. Next state by `entrada`:
  - 000000 → EXEC_R.
  - 100011, 101011, and enabled 001000 → ENDERECO.
  - 000100 → BEQ.
  - Enabled 000010 → JUMP.
  - Anything else → ILEGAL.
- ENDERECO: alusrca=1, alusrcb=10, aluop=00. Next state: lw → MEM_LE, sw → MEM_ESC, addi → WB_ADDI. The opcode is held in an internal register captured in DECODIFICA.
- MEM_LE: memread=1, iord=1. Stays while mem_ready=0; then goes to WB_LW.
- WB_LW: regwrite=1, memtoreg=1, regdst=0. Then BUSCA.
- MEM_ESC: memwrite=1, iord=1. Stays while mem_ready=0; then goes to BUSCA.
- EXEC_R: alusrca=1, alusrcb=00, aluop=10. Then WB_R.
- WB_R: regwrite=1, regdst=1, memtoreg=0. Then BUSCA.
- WB_ADDI: regwrite=1, regdst=0, memtoreg=0. Then BUSCA.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Then BUSCA.
- JUMP: pcwrite=1, pcsource=10. Then BUSCA.
- ILEGAL: ilegal=1. Then BUSCA; the PC has already advanced, so the bad instruction is skipped.

## Timing
- Outputs are a pure combinational decode of the state register. No output depends on `entrada`.
- BUSCA's irwrite and pcwrite are the only outputs gated by mem_ready.
- Cycle counts with mem_ready tied to 1, counted from entering BUSCA:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 3.
- Each cycle with mem_ready=0 in BUSCA, MEM_LE or MEM_ESC adds exactly one cycle. There is no timeout.
- `rst_n` low at any point, including mid-stall or mid-instruction:
  - State goes to RESET immediately (asynchronously) and all outputs go to 0 without waiting for a clock.
  - The captured-opcode register clears to 0.
- After `rst_n` rises, the first edge moves to RESET→BUSCA, so memread rises one cycle after release.
- A write strobe (memwrite, regwrite, pcwrite, pcwritecond) is never asserted in two consecutive states for the same instruction, except pcwrite in a stalled BUSCA, where it follows mem_ready.

## Structure
- Shared package `controlador_pkg` holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - aluop codes;
  - alusrcb and pcsource codes;
  - the 4-bit state encodings.
- Sub-module `controlador_saidas`: a combinational state→output decoder. The top level holds the state register, the opcode capture register and the next-state logic.

## Test plan
- Reset with `rst_n`=0 mid-MEM_LE → all outputs 0 in the same cycle, `estado`=RESET; after release, BUSCA and memread=1 one cycle later.
- R-type (000000), mem_ready=1 → states BUSCA, DECODIFICA, EXEC_R (aluop=10), WB_R (regwrite=1, regdst=1), back to BUSCA: 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEM_LE → MEM_LE held 3 cycles; WB_LW has memtoreg=1; total 7 cycles.
- sw (101011), then beq (000100) → MEM_ESC has memwrite=1, iord=1; BEQ has pcwritecond=1, pcsource=01, aluop=01.
- j (000010) and addi (001000) with both enables=1 → JUMP has pcwrite=1, pcsource=10; WB_ADDI has regwrite=1, regdst=0.
- Opcode 111111, then addi with PERMITE_ADDI=0 → each gives an ILEGAL state with one ilegal pulse and no regwrite or memwrite asserted.
